frame_buf_sched: RTL

//  Ping-pong ownership scheduler for the two 480x272 RGB565 camera frame buffers.

---
 rtl/cam_buf_pkg.sv | 31 +++
 rtl/sat_counter.sv | 40 ++++
 rtl/frame_buf_sched.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/cam_buf_pkg.sv
// cam_buf_pkg: shared definitions for the camera frame-buffer pair.
//   Buffer geometry (480x272 RGB565, one 16-bit word per pixel), the
//   per-buffer ownership state codes, and small lookup helpers for the
//   two-buffer state pair.
package cam_buf_pkg;

    localparam int unsigned FRAME_W   = 480;
    localparam int unsigned FRAME_H   = 272;
    localparam int unsigned BUF_WORDS = FRAME_W * FRAME_H;

    // Ownership state of one frame buffer
    typedef enum logic [1:0] {
        BUF_FREE    = 2'd0,
        BUF_WRITING = 2'd1,
        BUF_FULL    = 2'd2,
        BUF_READING = 2'd3
    } buf_st_e;

    // True when either buffer is in state want
    function automatic logic st_any(input buf_st_e s0, input buf_st_e s1,
                                    input buf_st_e want);
        return (s0 == want) || (s1 == want);
    endfunction

    // Index of the buffer in state want (0 preferred); only meaningful when st_any()
    function automatic logic st_idx(input buf_st_e s0, input buf_st_e s1,
                                    input buf_st_e want);
        return (s0 != want) && (s1 == want);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// sat_counter: saturating event counter, cleared only by reset.
//   Only exists in the statistics build (FRAME_SCHED_STATS_EN).
// Ports:
//   clk    in  1      clock
//   rst_n  in  1      asynchronous active-low reset
//   inc    in  1      count one event this cycle
//   count  out CNT_W  registered event count, holds at all-ones
`ifdef FRAME_SCHED_STATS_EN
module sat_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Increment unless already saturated
    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {CNT_W{1'b1}})) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= CNT_W'(0);
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule
`endif

// File: rtl/frame_buf_sched.sv
// frame_buf_sched: ping-pong ownership scheduler for the two camera frame
//   buffers. The writer never shares a buffer with the reader, the reader
//   always gets the newest complete frame; stale frames are dropped when
//   the writer runs ahead and the last frame is repeated when it lags.
// Build option: FRAME_SCHED_STATS_EN enables the drop/repeat counters;
//   without it drop_cnt_o/rep_cnt_o are tied to 0.
// Ports:
//   iClk, wRsn            clock, asynchronous active-low reset
//   wr_fs_i / wr_fe_i     writer frame start / end pulses
//   rd_fs_i / rd_fe_i     reader frame start / end pulses
//   wr_grant_o, wr_buf_o  writer owns buffer wr_buf_o
//   rd_valid_o, rd_buf_o  reader owns buffer rd_buf_o (0 = show blank)
//   buf0_st_o, buf1_st_o  ownership state of each buffer
//   drop_cnt_o, rep_cnt_o saturating drop / repeat statistics
module frame_buf_sched
    import cam_buf_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic             iClk,
    input  logic             wRsn,
    input  logic             wr_fs_i,
    input  logic             wr_fe_i,
    input  logic             rd_fs_i,
    input  logic             rd_fe_i,
    output logic             wr_grant_o,
    output logic             wr_buf_o,
    output logic             rd_valid_o,
    output logic             rd_buf_o,
    output logic [1:0]       buf0_st_o,
    output logic [1:0]       buf1_st_o,
    output logic [CNT_W-1:0] drop_cnt_o,
    output logic [CNT_W-1:0] rep_cnt_o
);

    buf_st_e st_q [2];
    buf_st_e st_d [2];
    logic    wr_grant_q, wr_grant_d;
    logic    wr_buf_q,   wr_buf_d;
    logic    rd_valid_q, rd_valid_d;
    logic    rd_buf_q,   rd_buf_d;
    logic    last_wr_q,  last_wr_d;   // buffer most recently handed to the writer
    logic    prev_rd_q,  prev_rd_d;   // buffer most recently handed to the reader
    logic    prev_vld_q, prev_vld_d;  // prev_rd_q is meaningful
    logic    fe_seen_q,  fe_seen_d;   // a frame completed since the last read grant
    logic    drop_inc;
    logic    rep_inc;
    logic    idx;

    // Resolve same-cycle events in order rd_fe, wr_fe, rd_fs, wr_fs,
    // each step working on the result of the previous one.
    always_comb begin
        st_d       = st_q;
        wr_grant_d = wr_grant_q;
        wr_buf_d   = wr_buf_q;
        rd_valid_d = rd_valid_q;
        rd_buf_d   = rd_buf_q;
        last_wr_d  = last_wr_q;
        prev_rd_d  = prev_rd_q;
        prev_vld_d = prev_vld_q;
        fe_seen_d  = fe_seen_q;
        drop_inc   = 1'b0;
        rep_inc    = 1'b0;
        idx        = 1'b0;

        // Reader done: keep the frame for a possible repeat unless a newer one waits
        if (rd_fe_i) begin
            if (st_any(st_d[0], st_d[1], BUF_READING)) begin
                idx       = st_idx(st_d[0], st_d[1], BUF_READING);
                st_d[idx] = (st_d[~idx] == BUF_FULL) ? BUF_FREE : BUF_FULL;
            end
            rd_valid_d = 1'b0;
        end

        // Writer done: new frame supersedes any older complete frame
        if (wr_fe_i && st_any(st_d[0], st_d[1], BUF_WRITING)) begin
            idx       = st_idx(st_d[0], st_d[1], BUF_WRITING);
            st_d[idx] = BUF_FULL;
            if (st_d[~idx] == BUF_FULL) begin
                st_d[~idx] = BUF_FREE;
                drop_inc   = 1'b1;
            end
            wr_grant_d = 1'b0;
            fe_seen_d  = 1'b1;
        end

        // Reader start: release a buffer whose end pulse was missed, take the newest frame
        if (rd_fs_i) begin
            if (st_any(st_d[0], st_d[1], BUF_READING)) begin
                st_d[st_idx(st_d[0], st_d[1], BUF_READING)] = BUF_FREE;
            end
            if (st_any(st_d[0], st_d[1], BUF_FULL)) begin
                idx        = st_idx(st_d[0], st_d[1], BUF_FULL);
                st_d[idx]  = BUF_READING;
                rd_buf_d   = idx;
                rd_valid_d = 1'b1;
                rep_inc    = prev_vld_q && (prev_rd_q == idx) && !fe_seen_d;
                prev_rd_d  = idx;
                prev_vld_d = 1'b1;
                fe_seen_d  = 1'b0;
            end else begin
                rd_valid_d = 1'b0;
            end
        end

        // Writer start: prefer a free buffer, else overwrite the waiting frame
        if (wr_fs_i) begin
            if (st_any(st_d[0], st_d[1], BUF_WRITING)) begin
                idx      = st_idx(st_d[0], st_d[1], BUF_WRITING);
                drop_inc = 1'b1;
            end else if ((st_d[0] == BUF_FREE) && (st_d[1] == BUF_FREE)) begin
                idx = ~last_wr_q;
            end else if (st_any(st_d[0], st_d[1], BUF_FREE)) begin
                idx = st_idx(st_d[0], st_d[1], BUF_FREE);
            end else begin
                // Remaining pair is FULL + READING: the reader's buffer is never taken
                idx      = st_idx(st_d[0], st_d[1], BUF_FULL);
                drop_inc = 1'b1;
            end
            st_d[idx]  = BUF_WRITING;
            wr_buf_d   = idx;
            wr_grant_d = 1'b1;
            last_wr_d  = idx;
        end
    end

    always_ff @(posedge iClk or negedge wRsn) begin
        if (!wRsn) begin
            st_q[0]    <= BUF_FREE;
            st_q[1]    <= BUF_FREE;
            wr_grant_q <= 1'b0;
            wr_buf_q   <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_buf_q   <= 1'b0;
            last_wr_q  <= 1'b1;
            prev_rd_q  <= 1'b0;
            prev_vld_q <= 1'b0;
            fe_seen_q  <= 1'b0;
        end else begin
            st_q       <= st_d;
            wr_grant_q <= wr_grant_d;
            wr_buf_q   <= wr_buf_d;
            rd_valid_q <= rd_valid_d;
            rd_buf_q   <= rd_buf_d;
            last_wr_q  <= last_wr_d;
            prev_rd_q  <= prev_rd_d;
            prev_vld_q <= prev_vld_d;
            fe_seen_q  <= fe_seen_d;
        end
    end

    assign wr_grant_o = wr_grant_q;
    assign wr_buf_o   = wr_buf_q;
    assign rd_valid_o = rd_valid_q;
    assign rd_buf_o   = rd_buf_q;
    assign buf0_st_o  = st_q[0];
    assign buf1_st_o  = st_q[1];

`ifdef FRAME_SCHED_STATS_EN
    sat_counter #(.CNT_W(CNT_W)) u_drop_cnt (
        .clk   (iClk),
        .rst_n (wRsn),
        .inc   (drop_inc),
        .count (drop_cnt_o)
    );

    sat_counter #(.CNT_W(CNT_W)) u_rep_cnt (
        .clk   (iClk),
        .rst_n (wRsn),
        .inc   (rep_inc),
        .count (rep_cnt_o)
    );
`else
    logic unused_stats;
    assign unused_stats = drop_inc ^ rep_inc;
    assign drop_cnt_o   = CNT_W'(0);
    assign rep_cnt_o    = CNT_W'(0);
`endif

endmodule
